// File: rtl/reg_file_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional feature macro: REG_FILE_SB_BYPASS_EN (write-to-read forwarding).
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  // One write-port request at the default geometry.
  typedef struct packed {
    logic                  en;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending write, grants
// reservations, and keeps a registered count of busy bits.
// Clear/set priority: a write clears a bit, a granted reserve on the same
// edge sets it again (reserve wins).
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     rsv_ok,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_cnt_nxt;

  // Grant uses the pre-edge busy vector only; same-cycle writes do not help.
  always_comb begin
    rsv_ok = ~r_busy[rsv_addr];
  end

  // Next busy vector: writes clear, granted reserve sets afterwards.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr0_en && (wr0_addr == ADDR_W'(i))) w_busy_nxt[i] = 1'b0;
      if (wr1_en && (wr1_addr == ADDR_W'(i))) w_busy_nxt[i] = 1'b0;
      if (rsv_en && rsv_ok && (rsv_addr == ADDR_W'(i))) w_busy_nxt[i] = 1'b1;
    end
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
    end
  end

  // Busy vector and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two read ports, two write ports and a busy-bit
// scoreboard for pending-write reservations.
// Optional feature macro: REG_FILE_SB_BYPASS_EN -- when defined, a read
// whose address matches an enabled write returns that write's data (port 1
// over port 0) and reports not-busy in the same cycle.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;

  logic [1:0][ADDR_W-1:0] w_rd_addr;
  logic [1:0][DATA_W-1:0] w_rd_data;
  logic [1:0]             w_rd_busy;

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (w_busy),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  // Storage array; port 1 wins a same-address collision, register 0 is
  // left at its reset value when hardwired to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((ZERO_REG == 0) || (i != 0)) begin
          if (wr1_en && (wr1_addr == ADDR_W'(i)))      r_mem[i] <= wr1_data;
          else if (wr0_en && (wr0_addr == ADDR_W'(i))) r_mem[i] <= wr0_data;
        end
      end
    end
  end

  assign w_rd_addr = {rd_addr2, rd_addr1};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    // Combinational read mux with optional write forwarding.
    always_comb begin
      w_rd_data[p] = r_mem[w_rd_addr[p]];
      w_rd_busy[p] = w_busy[w_rd_addr[p]];
`ifdef REG_FILE_SB_BYPASS_EN
      if (wr1_en && (wr1_addr == w_rd_addr[p])) begin
        w_rd_data[p] = wr1_data;
        w_rd_busy[p] = 1'b0;
      end else if (wr0_en && (wr0_addr == w_rd_addr[p])) begin
        w_rd_data[p] = wr0_data;
        w_rd_busy[p] = 1'b0;
      end
`endif
      if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  assign rd_data1 = w_rd_data[0];
  assign rd_data2 = w_rd_data[1];
  assign rd_busy1 = w_rd_busy[0];
  assign rd_busy2 = w_rd_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (default geometry, ZERO_REG=1).
// Inputs change 1ns after each rising edge; outputs are compared on the
// falling edge against a behavioural model of the register file.
module tb_reg_file_sb;
  import reg_file_pkg::*;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rd_addr1 = '0, rd_addr2 = '0;
  logic [15:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        wr0_en = 1'b0, wr1_en = 1'b0;
  logic [3:0]  wr0_addr = '0, wr1_addr = '0;
  logic [15:0] wr0_data = '0, wr1_data = '0;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_addr = '0;
  logic        rsv_ok;
  logic [4:0]  busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_cnt(busy_cnt)
  );

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem  [16];
  logic        m_busy [16];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic m_ok(logic [3:0] a);
    return (a == 4'd0) || !m_busy[a];
  endfunction

  function automatic logic [15:0] m_rdata(logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (BYP && wr1_en && wr1_addr == a) return wr1_data;
    if (BYP && wr0_en && wr0_addr == a) return wr0_data;
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(logic [3:0] a);
    if (a == 4'd0) return 1'b0;
    if (BYP && ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  // Model state update: register i takes port 1 data if port 1 targets it,
  // else port 0 data; a write frees the register unless a granted reserve
  // targets it in the same cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < 16; i++) begin
        logic hit0, hit1, take;
        hit0 = wr0_en && (int'(wr0_addr) == i);
        hit1 = wr1_en && (int'(wr1_addr) == i);
        take = rsv_en && (int'(rsv_addr) == i) && !m_busy[i];
        if (hit1)      m_mem[i] <= wr1_data;
        else if (hit0) m_mem[i] <= wr0_data;
        if (take)              m_busy[i] <= 1'b1;
        else if (hit0 || hit1) m_busy[i] <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;

  // Every cycle out of reset: all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cmp_rd_data1", 32'(rd_data1), 32'(m_rdata(rd_addr1)));
      chk("cmp_rd_data2", 32'(rd_data2), 32'(m_rdata(rd_addr2)));
      chk("cmp_rd_busy1", 32'(rd_busy1), 32'(m_rbusy(rd_addr1)));
      chk("cmp_rd_busy2", 32'(rd_busy2), 32'(m_rbusy(rd_addr2)));
      chk("cmp_rsv_ok",   32'(rsv_ok),   32'(m_ok(rsv_addr)));
      chk("cmp_busy_cnt", 32'(busy_cnt), 32'(m_count()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input wr_req_t w0, input wr_req_t w1,
                       input logic ren, input logic [3:0] ra,
                       input logic [3:0] a1, input logic [3:0] a2);
    wr0_en = w0.en; wr0_addr = w0.addr; wr0_data = w0.data;
    wr1_en = w1.en; wr1_addr = w1.addr; wr1_data = w1.data;
    rsv_en = ren;   rsv_addr = ra;
    rd_addr1 = a1;  rd_addr2 = a2;
  endtask

  task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
    drive('0, '0, 1'b0, 4'd0, a1, a2);
  endtask

  function automatic wr_req_t wr(input logic [3:0] a, input logic [15:0] d);
    wr_req_t r;
    r.en = 1'b1; r.addr = a; r.data = d;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  cnt_before;
    logic [15:0] old7;

    #17 rst = 1'b0;

    // Reset contents: every address reads zero and not busy.
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 4'(i);
      rd_addr2 = 4'(15 - i);
      #1;
      chk("rst_data1", 32'(rd_data1), 32'h0);
      chk("rst_data2", 32'(rd_data2), 32'h0);
      chk("rst_busy1", 32'(rd_busy1), 32'h0);
    end
    chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
    tick();
    cmp_en = 1'b1;

    // Same-address dual write: port 1 wins.
    drive(wr(4'd3, 16'h1234), wr(4'd3, 16'hBEEF), 1'b0, 4'd0, 4'd3, 4'd3);
    @(negedge clk);
    chk("dual_wr_same_cycle", 32'(rd_data1), BYP ? 32'hBEEF : 32'h0);
    tick();
    idle(4'd3, 4'd0);
    @(negedge clk);
    chk("dual_wr_port1_wins", 32'(rd_data1), 32'hBEEF);
    tick();

    // Reserve 5, re-reserve refused, write frees it.
    drive('0, '0, 1'b1, 4'd5, 4'd5, 4'd0);
    @(negedge clk);
    chk("rsv5_ok", 32'(rsv_ok), 32'h1);
    tick();
    drive('0, '0, 1'b1, 4'd5, 4'd5, 4'd0);
    @(negedge clk);
    chk("rsv5_again_ok", 32'(rsv_ok), 32'h0);
    chk("rsv5_cnt", 32'(busy_cnt), 32'h1);
    chk("rsv5_busy", 32'(rd_busy1), 32'h1);
    tick();
    drive(wr(4'd5, 16'h00AA), '0, 1'b0, 4'd0, 4'd5, 4'd0);
    @(negedge clk);
    chk("rsv5_cnt_held", 32'(busy_cnt), 32'h1);
    tick();
    idle(4'd5, 4'd0);
    @(negedge clk);
    chk("wr5_cnt", 32'(busy_cnt), 32'h0);
    chk("wr5_busy", 32'(rd_busy1), 32'h0);
    chk("wr5_data", 32'(rd_data1), 32'h00AA);
    tick();

    // Forwarding behaviour on address 7.
    drive(wr(4'd7, 16'h1111), '0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    old7 = 16'h1111;
    drive('0, wr(4'd7, 16'h5A5A), 1'b0, 4'd0, 4'd0, 4'd7);
    @(negedge clk);
    chk("byp7_same_cycle", 32'(rd_data2), BYP ? 32'h5A5A : 32'(old7));
    tick();
    idle(4'd0, 4'd7);
    @(negedge clk);
    chk("byp7_next_cycle", 32'(rd_data2), 32'h5A5A);
    tick();

    // Hardwired register 0.
    cnt_before = busy_cnt;
    drive(wr(4'd0, 16'hFFFF), '0, 1'b1, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("zr_rsv_ok", 32'(rsv_ok), 32'h1);
    chk("zr_data_same", 32'(rd_data1), 32'h0);
    tick();
    idle(4'd0, 4'd0);
    @(negedge clk);
    chk("zr_data", 32'(rd_data1), 32'h0);
    chk("zr_busy", 32'(rd_busy1), 32'h0);
    chk("zr_cnt", 32'(busy_cnt), 32'(cnt_before));
    tick();

    // Reserve 1,2,3 then asynchronous reset between edges.
    for (int i = 1; i <= 3; i++) begin
      drive('0, '0, 1'b1, 4'(i), 4'd1, 4'd2);
      tick();
    end
    drive(wr(4'd9, 16'h9999), '0, 1'b1, 4'd4, 4'd1, 4'd2);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(busy_cnt), 32'h3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(busy_cnt), 32'h0);
    chk("arst_busy1", 32'(rd_busy1), 32'h0);
    chk("arst_busy2", 32'(rd_busy2), 32'h0);
    rsv_addr = 4'd3;
    #1;
    chk("arst_rsv_ok3", 32'(rsv_ok), 32'h1);
    idle(4'd9, 4'd3);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("arst_wr_dropped", 32'(rd_data1), 32'h0);
    tick();

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      wr_req_t w0, w1;
      logic [3:0] hi;
      hi = (n % 3 == 0) ? 4'd3 : 4'd15;
      w0.en = ($urandom_range(0, 9) < 4);
      w0.addr = 4'($urandom_range(0, int'(hi)));
      w0.data = 16'($urandom);
      w1.en = ($urandom_range(0, 9) < 4);
      w1.addr = 4'($urandom_range(0, int'(hi)));
      w1.data = 16'($urandom);
      drive(w0, w1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, int'(hi))),
            4'($urandom_range(0, int'(hi))), 4'($urandom_range(0, 15)));
      tick();
    end

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 16: register width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rd_addr1, rd_addr2  in  ADDR_W  read port addresses.
REQ-007 rd_data1, rd_data2  out  DATA_W  read data, combinational from address.
REQ-008 rd_busy1, rd_busy2  out  1  addressed register has a pending write.
REQ-009 wr0_en, wr1_en  in  1  write enables for write ports 0 and 1.
REQ-010 wr0_addr, wr1_addr  in  ADDR_W  write addresses.
REQ-011 wr0_data, wr1_data  in  DATA_W  write data.
REQ-012 rsv_en  in  1  request to reserve rsv_addr as pending-write destination.
REQ-013 rsv_addr  in  ADDR_W  register to reserve.
REQ-014 rsv_ok  out  1  combinational grant; 0 when rsv_addr is already busy.
REQ-015 busy_cnt  out  ADDR_W+1  registered count of busy bits currently set.

Function
REQ-016 Storage: DEPTH x DATA_W array plus DEPTH-bit busy vector.
REQ-017 Write: on clk edge, each enabled port writes its data to its address.
REQ-018 Same-address dual write: port 1 data wins; port 0 write is dropped.
REQ-019 Any write to an address clears its busy bit on the same edge.
REQ-020 Reserve: rsv_en & rsv_ok sets busy[rsv_addr] on the edge; rsv_en & ~rsv_ok changes nothing.
REQ-021 Reserve and write to same address in one cycle: data written, busy bit ends set (reserve wins).
REQ-022 rsv_ok = ~busy[rsv_addr], using the pre-edge busy vector, independent of same-cycle writes.
REQ-023 Read: rd_dataN = array[rd_addrN], rd_busyN = busy[rd_addrN], zero latency.
REQ-024 ZERO_REG=1: address 0 reads 0, is never busy, ignores writes, and always gives rsv_ok=1 without setting a bit.
REQ-025 busy_cnt equals popcount of busy vector after each edge; it never exceeds DEPTH and never underflows.

Reset
REQ-026 rst high: all registers, busy bits and busy_cnt go to 0 immediately, without waiting for clk.
REQ-027 Reset mid-operation discards in-flight writes and reservations; first edge after rst deasserts operates normally.

Configuration
REQ-028 Macro REG_FILE_SB_BYPASS_EN defined: a read address matching an enabled write address returns that write data (port 1 over port 0) and rd_busy=0 in the same cycle.
REQ-029 Macro undefined: reads return stored array contents and stored busy bit only; the new value is visible the cycle after the write.

Structure
REQ-030 Package reg_file_pkg holds default DATA_W/ADDR_W constants and the write-port request typedef (en, addr, data).
REQ-031 Sub-module reg_file_scoreboard holds the busy vector, rsv_ok, clear/set priority and busy_cnt; the top level holds the array and read/bypass muxing.

Verification
REQ-032 Reset, then read all 16 addresses -> data 0x0000, busy 0, busy_cnt 0.
REQ-033 wr0 addr 3 0x1234 and wr1 addr 3 0xBEEF in the same cycle -> next cycle reg 3 reads 0xBEEF.
REQ-034 Reserve addr 5 -> rsv_ok=1, busy_cnt 1. Reserve 5 again -> rsv_ok=0, busy_cnt stays 1. Write 5 with 0x00AA -> busy clears, busy_cnt 0.
REQ-035 With BYPASS_EN, read addr 7 while wr1 writes 0x5A5A to 7 -> rd_data 0x5A5A in that cycle. Without BYPASS_EN -> old value, then 0x5A5A next cycle.
REQ-036 ZERO_REG=1: write 0xFFFF to addr 0 and reserve addr 0 -> reads 0x0000, busy 0, busy_cnt unchanged.
REQ-037 Reserve addrs 1, 2, 3, then assert rst asynchronously between edges -> busy_cnt and all busy bits 0 before the next edge.
